// File: rtl/psum_accumulator.sv
// psum_accumulator: sums each window of ACC_LEN valid products into one
// signed partial sum. It can saturate or wrap on overflow and flags any
// overflow in the window. It freezes on the same global stall as the
// upstream delayer.
//
// state | meaning
// IDLE  | count == 0, no partial sum held (acc treated as zero)
// ACCUM | 0 < count < ACC_LEN, acc holds the running window sum
//
// The beat counter is the state, so there is no separate state register.
module psum_accumulator #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 40,
  parameter int ACC_LEN   = 9,
  parameter int SAT       = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                stall,
  input  logic                                clear,
  input  logic                                in_valid,
  input  logic signed [IN_WIDTH-1:0]          in,
  output logic signed [OUT_WIDTH-1:0]         out,
  output logic                                out_valid,
  output logic                                ovf,
  output logic [$clog2(ACC_LEN+1)-1:0]        count
);

  localparam int CW = $clog2(ACC_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(ACC_LEN - 1);
  localparam logic signed [OUT_WIDTH-1:0] MAX_V = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] MIN_V = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic signed [OUT_WIDTH-1:0] acc, acc_n, out_n, sum;
  logic signed [OUT_WIDTH:0]   base_x, in_x, wide;
  logic [CW-1:0]               count_n;
  logic                        sticky, sticky_n, out_valid_n, ovf_n;
  logic                        beat_ovf, last;

  // One extra bit of headroom exposes signed overflow as a top-two-bit mismatch.
  always_comb begin
    base_x   = (count == '0) ? '0 : {acc[OUT_WIDTH-1], acc};
    in_x     = {{(OUT_WIDTH+1-IN_WIDTH){in[IN_WIDTH-1]}}, in};
    wide     = base_x + in_x;
    beat_ovf = wide[OUT_WIDTH] ^ wide[OUT_WIDTH-1];
    if (beat_ovf && (SAT != 0)) sum = wide[OUT_WIDTH] ? MIN_V : MAX_V;
    else                        sum = wide[OUT_WIDTH-1:0];
    last     = (count == LAST);
  end

  // Next-state logic: clear beats stall, stall freezes everything, then accept.
  always_comb begin
    acc_n       = acc;
    count_n     = count;
    sticky_n    = sticky;
    out_n       = out;
    out_valid_n = out_valid;
    ovf_n       = ovf;
    if (clear) begin
      acc_n       = '0;
      count_n     = '0;
      sticky_n    = 1'b0;
      out_valid_n = 1'b0;
      ovf_n       = 1'b0;
    end else if (!stall) begin
      out_valid_n = 1'b0;
      ovf_n       = 1'b0;
      if (in_valid) begin
        if (last) begin
          out_n       = sum;
          out_valid_n = 1'b1;
          ovf_n       = sticky | beat_ovf;
          acc_n       = '0;
          count_n     = '0;
          sticky_n    = 1'b0;
        end else begin
          acc_n    = sum;
          count_n  = count + CW'(1);
          sticky_n = sticky | beat_ovf;
        end
      end
    end
  end

  // State register with synchronous reset that discards any partial window.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      count     <= '0;
      sticky    <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      acc       <= acc_n;
      count     <= count_n;
      sticky    <= sticky_n;
      out       <= out_n;
      out_valid <= out_valid_n;
      ovf       <= ovf_n;
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Scoreboard bench for psum_accumulator: stimulus pushes expected window
// results, per-instance monitors pop and compare on each new out_valid pulse.
module tb_psum_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, stall, clear, in_valid;
  logic signed [31:0] in_d;
  logic signed [39:0] out;
  logic               out_valid, ovf;
  logic [3:0]         count;

  logic              in_valid8;
  logic signed [7:0] in8;
  logic signed [7:0] out_s, out_w;
  logic              ov_s, ov_w, of_s, of_w;
  logic [3:0]        cnt_s, cnt_w;

  int checks = 0;
  int errors = 0;

  typedef struct { logic signed [39:0] v; logic o; } exp_t;
  typedef struct { logic signed [7:0] v; logic o; } exp8_t;
  exp_t  q[$];
  exp8_t qs[$];
  exp8_t qw[$];

  psum_accumulator #(.IN_WIDTH(32), .OUT_WIDTH(40), .ACC_LEN(9), .SAT(1)) dut (
    .clk(clk), .rst(rst), .stall(stall), .clear(clear), .in_valid(in_valid),
    .in(in_d), .out(out), .out_valid(out_valid), .ovf(ovf), .count(count));

  psum_accumulator #(.IN_WIDTH(8), .OUT_WIDTH(8), .ACC_LEN(9), .SAT(1)) dut_sat (
    .clk(clk), .rst(rst), .stall(1'b0), .clear(1'b0), .in_valid(in_valid8),
    .in(in8), .out(out_s), .out_valid(ov_s), .ovf(of_s), .count(cnt_s));

  psum_accumulator #(.IN_WIDTH(8), .OUT_WIDTH(8), .ACC_LEN(9), .SAT(0)) dut_wrap (
    .clk(clk), .rst(rst), .stall(1'b0), .clear(1'b0), .in_valid(in_valid8),
    .in(in8), .out(out_w), .out_valid(ov_w), .ovf(of_w), .count(cnt_w));

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic beat(input logic v, input logic signed [31:0] x, input logic st, input logic cl);
    in_valid = v;
    in_d     = x;
    stall    = st;
    clear    = cl;
    @(negedge clk);
  endtask

  task automatic beat8(input logic v, input logic signed [7:0] x);
    in_valid8 = v;
    in8       = x;
    @(negedge clk);
  endtask

  // A held pulse across stalled edges is the same result, not a new one.
  logic prev_ov = 1'b0;
  logic stall_edge = 1'b0;
  always @(posedge clk) stall_edge <= stall;

  always @(negedge clk) begin
    exp_t e;
    if (out_valid && !(prev_ov && stall_edge)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL main_unexpected actual=%0d expected=none", out);
      end else begin
        e = q.pop_front();
        chk("main_out", out, e.v);
        chk("main_ovf", {39'd0, ovf}, {39'd0, e.o});
      end
    end
    prev_ov = out_valid;
  end

  always @(negedge clk) begin
    exp8_t e;
    if (ov_s) begin
      if (qs.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sat_unexpected actual=%0d expected=none", out_s);
      end else begin
        e = qs.pop_front();
        chk("sat_out", 40'(out_s), 40'(e.v));
        chk("sat_ovf", {39'd0, of_s}, {39'd0, e.o});
      end
    end
  end

  always @(negedge clk) begin
    exp8_t e;
    if (ov_w) begin
      if (qw.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wrap_unexpected actual=%0d expected=none", out_w);
      end else begin
        e = qw.pop_front();
        chk("wrap_out", 40'(out_w), 40'(e.v));
        chk("wrap_ovf", {39'd0, of_w}, {39'd0, e.o});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; clear = 1'b0; in_valid = 1'b0; in_d = '0;
    in_valid8 = 1'b0; in8 = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out", out, 40'd0);
    chk("rst_valid", {39'd0, out_valid}, 40'd0);
    chk("rst_ovf", {39'd0, ovf}, 40'd0);
    chk("rst_count", 40'(count), 40'd0);
    rst = 1'b0;

    // Two back-to-back windows
    q.push_back('{40'sd45, 1'b0});
    for (int i = 1; i <= 9; i++) beat(1'b1, i, 1'b0, 1'b0);
    chk("t1_valid", {39'd0, out_valid}, 40'd1);
    chk("t1_count", 40'(count), 40'd0);
    q.push_back('{40'sd126, 1'b0});
    for (int i = 10; i <= 18; i++) begin
      beat(1'b1, i, 1'b0, 1'b0);
      if (i == 10) chk("t1_pulse_one_cycle", {39'd0, out_valid}, 40'd0);
    end
    chk("t1_second_valid", {39'd0, out_valid}, 40'd1);

    // Stall mid-window, then stall during the result pulse
    q.push_back('{40'sd45, 1'b0});
    for (int i = 1; i <= 4; i++) beat(1'b1, i, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      beat(1'b1, 100, 1'b1, 1'b0);
      chk("t2_hold_count", 40'(count), 40'd4);
    end
    for (int i = 5; i <= 9; i++) beat(1'b1, i, 1'b0, 1'b0);
    chk("t2_valid", {39'd0, out_valid}, 40'd1);
    for (int k = 0; k < 3; k++) begin
      beat(1'b0, 0, 1'b1, 1'b0);
      chk("t2_pulse_held", {39'd0, out_valid}, 40'd1);
    end
    beat(1'b0, 0, 1'b0, 1'b0);
    chk("t2_pulse_drop", {39'd0, out_valid}, 40'd0);

    // Gapped negative stream
    q.push_back('{-40'sd27, 1'b0});
    for (int k = 0; k < 17; k++) begin
      beat((k % 2) == 0, -3, 1'b0, 1'b0);
      if (k == 15) chk("t3_no_early_valid", {39'd0, out_valid}, 40'd0);
    end
    chk("t3_valid", {39'd0, out_valid}, 40'd1);
    chk("t3_count", 40'(count), 40'd0);

    // Clear aborts a partial window; out holds its last value
    for (int k = 0; k < 5; k++) beat(1'b1, 7, 1'b0, 1'b0);
    chk("t4_count5", 40'(count), 40'd5);
    beat(1'b1, 7, 1'b0, 1'b1);
    chk("t4_clear_count", 40'(count), 40'd0);
    chk("t4_out_hold", out, -40'sd27);
    q.push_back('{40'sd18, 1'b0});
    for (int k = 0; k < 9; k++) beat(1'b1, 2, 1'b0, 1'b0);
    chk("t4_valid", {39'd0, out_valid}, 40'd1);
    for (int k = 0; k < 3; k++) beat(1'b1, 5, 1'b0, 1'b0);
    beat(1'b1, 5, 1'b1, 1'b1);
    chk("t4_clear_in_stall", 40'(count), 40'd0);
    chk("t4_out_hold2", out, 40'sd18);
    beat(1'b1, 5, 1'b1, 1'b0);
    chk("t4_stall_after_clear", 40'(count), 40'd0);
    q.push_back('{40'sd9, 1'b0});
    for (int k = 0; k < 9; k++) beat(1'b1, 1, 1'b0, 1'b0);

    // Reset with the pulse high, then reset mid-window
    q.push_back('{40'sd27, 1'b0});
    for (int k = 0; k < 9; k++) beat(1'b1, 3, 1'b0, 1'b0);
    chk("t5_valid_before_rst", {39'd0, out_valid}, 40'd1);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_rst_out", out, 40'd0);
    chk("t5_rst_valid", {39'd0, out_valid}, 40'd0);
    for (int k = 0; k < 6; k++) beat(1'b1, 50, 1'b0, 1'b0);
    chk("t5_count6", 40'(count), 40'd6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_rst_count", 40'(count), 40'd0);
    q.push_back('{40'sd36, 1'b0});
    for (int k = 0; k < 9; k++) beat(1'b1, 4, 1'b0, 1'b0);
    chk("t5_valid", {39'd0, out_valid}, 40'd1);
    beat(1'b0, 0, 1'b0, 1'b0);

    // 8-bit saturate vs wrap
    qs.push_back('{8'sd127, 1'b1});
    qw.push_back('{-8'sd124, 1'b1});
    for (int k = 0; k < 9; k++) beat8(1'b1, 8'sd100);
    qs.push_back('{-8'sd128, 1'b1});
    qw.push_back('{8'sd124, 1'b1});
    for (int k = 0; k < 9; k++) beat8(1'b1, -8'sd100);
    qs.push_back('{8'sd9, 1'b0});
    qw.push_back('{8'sd9, 1'b0});
    for (int k = 0; k < 9; k++) beat8(1'b1, 8'sd1);
    // Overflow early in the window, final sum back in range: flag must stick
    qs.push_back('{-8'sd73, 1'b1});
    qw.push_back('{8'sd0, 1'b1});
    beat8(1'b1, 8'sd100);
    beat8(1'b1, 8'sd100);
    beat8(1'b1, -8'sd100);
    beat8(1'b1, -8'sd100);
    for (int k = 0; k < 5; k++) beat8(1'b1, 8'sd0);
    beat8(1'b0, 8'sd0);
    beat8(1'b0, 8'sd0);

    chk("cnt8_idle", {32'd0, cnt_s, cnt_w}, 40'd0);
    chk("queues_empty", 40'(q.size() + qs.size() + qw.size()), 40'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
